mac_sequencer: RTL and testbench

Controller that owns a two-stage pipelined multiply-accumulate core and uses it to compute dot products.
- Accepts a command carrying a vector length, then streams that many operand pairs through the core over valid/ready handshakes.
- Clears the accumulator at the start of each command, drains the pipeline, and returns the sum with a sticky overflow flag.
- Sits between an operand producer (memory reader or FIFO) and a result consumer.

---
 rtl/mac_pkg.sv | 16 +
 rtl/mac_core.sv | 55 +++++
 rtl/mac_sequencer.sv | 85 ++++++++
 tb/tb_mac_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared types and default widths for the dot-product sequencer and its MAC core.
package mac_pkg;

    localparam int DATA_W = 4;
    localparam int ACC_W  = 9;
    localparam int LEN_W  = 4;
    localparam int PROD_W = 2 * DATA_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/mac_core.sv
// Two-stage MAC: stage 1 registers an operand pair, stage 2 accumulates its product.
module mac_core
    import mac_pkg::*;
#(
    parameter int DATA_W = mac_pkg::DATA_W,
    parameter int ACC_W  = mac_pkg::ACC_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [ACC_W-1:0]  acc,
    output logic              ovf
);

    localparam int PW = 2 * DATA_W;

    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] b_reg;
    logic              valid_reg;
    logic [ACC_W-1:0]  acc_reg;
    logic              ovf_reg;
    logic [PW-1:0]     prod;
    logic [ACC_W:0]    sum_next;

    assign prod     = PW'(a_reg) * PW'(b_reg);
    assign sum_next = {1'b0, acc_reg} + (ACC_W + 1)'(prod);

    always_ff @(posedge clock) begin
        if (!reset || clear) begin
            a_reg     <= '0;
            b_reg     <= '0;
            valid_reg <= 1'b0;
            acc_reg   <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            valid_reg <= in_valid;
            a_reg     <= a;
            b_reg     <= b;
            // The carry out of the truncated sum is sticky until the next clear.
            if (valid_reg) begin
                acc_reg <= sum_next[ACC_W-1:0];
                if (sum_next[ACC_W]) begin
                    ovf_reg <= 1'b1;
                end
            end
        end
    end

    assign acc = acc_reg;
    assign ovf = ovf_reg;

endmodule

// File: rtl/mac_sequencer.sv
// Dot-product controller: takes a length command, streams operand pairs through
// mac_core, drains the pipeline and holds the result until the consumer takes it.
module mac_sequencer
    import mac_pkg::*;
#(
    parameter int DATA_W = mac_pkg::DATA_W,
    parameter int ACC_W  = mac_pkg::ACC_W,
    parameter int LEN_W  = mac_pkg::LEN_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              cmd_ready,
    input  logic              op_valid,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              op_ready,
    output logic              res_valid,
    output logic [ACC_W-1:0]  res_data,
    output logic              res_ovf,
    input  logic              res_ready,
    output logic              busy
);

    state_t            state_reg;
    state_t            state_next;
    logic [LEN_W-1:0]  cnt_reg;
    logic              core_clear;
    logic              core_in_valid;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:  if (cmd_valid) state_next = (cmd_len != '0) ? RUN : DONE;
            RUN:   if (op_valid && cnt_reg == LEN_W'(1)) state_next = DRAIN;
            DRAIN: state_next = DONE;
            DONE:  if (res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready     = (state_reg == IDLE);
        op_ready      = (state_reg == RUN);
        res_valid     = (state_reg == DONE);
        busy          = (state_reg != IDLE);
        core_clear    = (state_reg == IDLE) && cmd_valid;
        core_in_valid = (state_reg == RUN) && op_valid;
    end

    // Remaining beats; only handshaken beats count, bubbles leave it alone.
    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_reg <= '0;
        end else if (core_clear) begin
            cnt_reg <= cmd_len;
        end else if (core_in_valid) begin
            cnt_reg <= cnt_reg - LEN_W'(1);
        end
    end

    mac_core #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_core (
        .clock    (clock),
        .reset    (reset),
        .clear    (core_clear),
        .in_valid (core_in_valid),
        .a        (op_a),
        .b        (op_b),
        .acc      (res_data),
        .ovf      (res_ovf)
    );

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer: a vector table of dot products plus
// hand-written sequences for backpressure, mid-run reset and ignored inputs.
module tb_mac_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [3:0] cmd_len = '0;
    logic       cmd_ready;
    logic       op_valid = 1'b0;
    logic [3:0] op_a = '0;
    logic [3:0] op_b = '0;
    logic       op_ready;
    logic       res_valid;
    logic [8:0] res_data;
    logic       res_ovf;
    logic       res_ready = 1'b0;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int qa[16];
    int qb[16];

    typedef struct {
        int              len;
        int              gap;
        logic [3:0][3:0] a;
        logic [3:0][3:0] b;
        int              exp_d;
        int              exp_o;
    } vec_t;

    vec_t vecs[7];

    always #5 clock = ~clock;

    mac_sequencer dut (
        .clock     (clock),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_len   (cmd_len),
        .cmd_ready (cmd_ready),
        .op_valid  (op_valid),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_ready  (op_ready),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_ovf   (res_ovf),
        .res_ready (res_ready),
        .busy      (busy)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, " cmd_ready"}, int'(cmd_ready), 1);
        check({nm, " op_ready"},  int'(op_ready),  0);
        check({nm, " res_valid"}, int'(res_valid), 0);
        check({nm, " res_data"},  int'(res_data),  0);
        check({nm, " res_ovf"},   int'(res_ovf),   0);
        check({nm, " busy"},      int'(busy),      0);
    endtask

    // Issue a command, stream len pairs from qa/qb with gap idle cycles between
    // beats, wait for the result, check it and complete the result handshake.
    task automatic run_cmd(input int len, input int gap, input int exp_d,
                           input int exp_o, input string nm);
        int  lat;
        int  exp_lat;
        bit  got;
        cmd_valid = 1'b1;
        cmd_len   = len[3:0];
        check({nm, " cmd_ready"}, int'(cmd_ready), 1);
        tick();
        cmd_valid = 1'b0;
        lat = 1;
        for (int i = 0; i < len; i++) begin
            if (i > 0) begin
                for (int g = 0; g < gap; g++) begin
                    tick();
                    lat++;
                end
            end
            op_valid = 1'b1;
            op_a     = qa[i][3:0];
            op_b     = qb[i][3:0];
            check($sformatf("%s op_ready beat%0d", nm, i), int'(op_ready), 1);
            tick();
            lat++;
            op_valid = 1'b0;
        end
        if (len > 0) check({nm, " op_ready in drain"}, int'(op_ready), 0);
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            if (res_valid) got = 1'b1;
            else begin
                tick();
                lat++;
            end
        end
        check({nm, " res_valid seen"}, int'(got), 1);
        exp_lat = (len == 0) ? 1 : len + 2 + (len - 1) * gap;
        check({nm, " latency"},   lat, exp_lat);
        check({nm, " res_data"},  int'(res_data), exp_d);
        check({nm, " res_ovf"},   int'(res_ovf), exp_o);
        check({nm, " busy"},      int'(busy), 1);
        check({nm, " cmd_ready in done"}, int'(cmd_ready), 0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check({nm, " res_valid after hs"}, int'(res_valid), 0);
        check({nm, " cmd_ready after hs"}, int'(cmd_ready), 1);
        $display("txn %s len=%0d data=%0d ovf=%0d lat=%0d", nm, len, res_data, res_ovf, lat);
    endtask

    initial begin
        vecs[0] = '{len: 3, gap: 0, a: {4'd0, 4'd1, 4'd4, 4'd2},
                    b: {4'd0, 4'd7, 4'd5, 4'd3}, exp_d: 33, exp_o: 0};
        vecs[1] = '{len: 2, gap: 3, a: {4'd0, 4'd0, 4'd5, 4'd3},
                    b: {4'd0, 4'd0, 4'd2, 4'd3}, exp_d: 19, exp_o: 0};
        vecs[2] = '{len: 3, gap: 0, a: {4'd0, 4'd15, 4'd15, 4'd15},
                    b: {4'd0, 4'd15, 4'd15, 4'd15}, exp_d: 163, exp_o: 1};
        vecs[3] = '{len: 1, gap: 0, a: {4'd0, 4'd0, 4'd0, 4'd1},
                    b: {4'd0, 4'd0, 4'd0, 4'd1}, exp_d: 1, exp_o: 0};
        vecs[4] = '{len: 4, gap: 1, a: {4'd7, 4'd5, 4'd3, 4'd1},
                    b: {4'd8, 4'd6, 4'd4, 4'd2}, exp_d: 100, exp_o: 0};
        vecs[5] = '{len: 4, gap: 0, a: {4'd15, 4'd15, 4'd15, 4'd15},
                    b: {4'd15, 4'd15, 4'd15, 4'd15}, exp_d: 388, exp_o: 1};
        vecs[6] = '{len: 4, gap: 2, a: {4'd9, 4'd0, 4'd15, 4'd15},
                    b: {4'd0, 4'd9, 4'd15, 4'd15}, exp_d: 450, exp_o: 0};

        reset = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset");
        reset = 1'b1;

        // Operands offered in IDLE must be neither consumed nor accumulated.
        op_valid = 1'b1; op_a = 4'd15; op_b = 4'd15;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle op_ready", int'(op_ready), 0);
            check("idle res_data", int'(res_data), 0);
            check("idle busy", int'(busy), 0);
        end
        op_valid = 1'b0;

        for (int v = 0; v < 7; v++) begin
            for (int i = 0; i < 4; i++) begin
                qa[i] = int'(vecs[v].a[i]);
                qb[i] = int'(vecs[v].b[i]);
            end
            run_cmd(vecs[v].len, vecs[v].gap, vecs[v].exp_d, vecs[v].exp_o,
                    $sformatf("vec%0d", v));
        end

        // Maximum length: 15 * 225 = 3375, 3375 mod 512 = 303.
        for (int i = 0; i < 15; i++) begin
            qa[i] = 15;
            qb[i] = 15;
        end
        run_cmd(15, 0, 303, 1, "maxlen");

        // Zero length, then hold the result under backpressure with stray inputs.
        cmd_valid = 1'b1; cmd_len = 4'd0;
        tick();
        check("len0 res_valid", int'(res_valid), 1);
        cmd_len = 4'd5; op_valid = 1'b1; op_a = 4'd15; op_b = 4'd15;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp res_valid", int'(res_valid), 1);
            check("bp res_data", int'(res_data), 0);
            check("bp res_ovf", int'(res_ovf), 0);
            check("bp cmd_ready", int'(cmd_ready), 0);
            check("bp op_ready", int'(op_ready), 0);
            check("bp busy", int'(busy), 1);
        end
        cmd_valid = 1'b0; op_valid = 1'b0; res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("bp cmd_ready after hs", int'(cmd_ready), 1);
        tick();
        check("bp busy idle", int'(busy), 0);
        $display("txn backpressure len=0 held 5 cycles");

        // Reset in the middle of a len=4 run after two beats.
        cmd_valid = 1'b1; cmd_len = 4'd4;
        tick();
        cmd_valid = 1'b0;
        op_valid = 1'b1; op_a = 4'd15; op_b = 4'd15;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1; op_valid = 1'b0;
        check_reset_outputs("midreset");
        $display("txn midrun reset after 2 beats");
        qa[0] = 6; qb[0] = 7;
        run_cmd(1, 0, 42, 0, "post_reset");

        // cmd_valid held through RUN and DRAIN: only one command is taken.
        cmd_valid = 1'b1; cmd_len = 4'd2;
        tick();
        cmd_len = 4'd3;
        op_valid = 1'b1; op_a = 4'd2; op_b = 4'd2;
        tick();
        op_a = 4'd3; op_b = 4'd3;
        tick();
        op_valid = 1'b0;
        check("hold drain busy", int'(busy), 1);
        tick();
        check("hold res_valid", int'(res_valid), 1);
        check("hold res_data", int'(res_data), 13);
        cmd_valid = 1'b0; res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        tick();
        check("hold idle cmd_ready", int'(cmd_ready), 1);
        check("hold idle busy", int'(busy), 0);
        $display("txn cmd_valid held in run data=13");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
